pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl_if.sv | 26 ++
 rtl/pc_ctrl.sv | 78 +++++++
 tb/tb_pc_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// Fetch-control bundle between the pipeline/imem side and pc_ctrl.
// master drives the control/ack inputs; slave is the PC controller.
interface pc_ctrl_if;
  logic        stall;
  logic        halt;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap;
  logic        imem_ack;
  logic [31:0] pc_out;
  logic        imem_req;
  logic        pc_valid;
  logic        halted;

  modport master (
    output stall, halt, br_taken, br_target,
    output trap, imem_ack,
    input  pc_out, imem_req, pc_valid, halted
  );

  modport slave (
    input  stall, halt, br_taken, br_target,
    input  trap, imem_ack,
    output pc_out, imem_req, pc_valid, halted
  );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter controller: BOOT/FETCH/HALT FSM with
// trap > branch > advance > hold next-PC selection.
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic      clk,
  input  logic      rst,
  pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] RST_PC =
    {RESET_VECTOR[31:2], 2'b00};
  localparam logic [31:0] TRAP_PC =
    {TRAP_VECTOR[31:2], 2'b00};

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic        halted_q;
  logic        in_fetch;
  logic        req;
  logic        valid;
  logic        redir_br;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RST_PC;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      halted_q <= (state_nx == HALT);
    end
  end

  always_comb begin
    in_fetch = (state == FETCH);
    req      = in_fetch & ~bus.stall;
    valid    = req & bus.imem_ack &
               ~bus.br_taken & ~bus.trap;
    // branch only counts in FETCH, and trap wins
    redir_br = in_fetch & bus.br_taken & ~bus.trap;

    pc_nx    = pc;
    state_nx = state;

    unique case (1'b1)
      bus.trap: pc_nx = TRAP_PC;
      redir_br: pc_nx = {bus.br_target[31:2], 2'b00};
      valid:    pc_nx = pc + 32'd4;
      default:  pc_nx = pc;
    endcase

    unique case (state)
      BOOT:    state_nx = FETCH;
      FETCH:   state_nx = bus.halt ? HALT : FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = BOOT;
    endcase

    if (bus.trap) state_nx = FETCH;
  end

  assign bus.pc_out   = pc;
  assign bus.imem_req = req;
  assign bus.pc_valid = valid;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed scenarios, then
// random stimulus against a behavioural PC model.
`timescale 1ns/1ps
module tb_pc_ctrl;

  localparam logic [31:0] TRAP_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_ctrl_if bus();

  pc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        valid;
    logic        halted;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_halt;

  function automatic void chk(string nm,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_pc   = 32'h0;
    m_boot = 1'b1;
    m_halt = 1'b0;
  endfunction

  function automatic exp_t predict(string tag);
    exp_t e;
    e.pc     = m_pc;
    e.halted = m_halt;
    e.req    = !rst && !m_boot && !m_halt && !bus.stall;
    e.valid  = e.req && bus.imem_ack &&
               !bus.br_taken && !bus.trap;
    e.tag    = tag;
    return e;
  endfunction

  function automatic void model_step();
    bit fetching;
    bit accepted;
    if (rst) begin
      model_reset();
    end else if (bus.trap) begin
      m_pc   = TRAP_PC;
      m_boot = 1'b0;
      m_halt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      fetching = !bus.stall;
      accepted = fetching && bus.imem_ack && !bus.br_taken;
      if (bus.br_taken)
        m_pc = {bus.br_target[31:2], 2'b00};
      else if (accepted)
        m_pc = m_pc + 32'd4;
      if (bus.halt) m_halt = 1'b1;
    end
  endfunction

  task automatic drive(bit s, bit h, bit b,
                       logic [31:0] t, bit tr, bit a);
    bus.stall     = s;
    bus.halt      = h;
    bus.br_taken  = b;
    bus.br_target = t;
    bus.trap      = tr;
    bus.imem_ack  = a;
  endtask

  task automatic cycle(bit r, bit s, bit h, bit b,
                       logic [31:0] t, bit tr, bit a,
                       string tag);
    @(negedge clk);
    rst = r;
    drive(s, h, b, t, tr, a);
    if (r) model_reset();
    sbq.push_back(predict(tag));
    @(posedge clk);
    model_step();
  endtask

  // monitor: compare whatever the driver queued this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, ".pc"},     bus.pc_out,   e.pc);
        chk({e.tag, ".req"},    32'(bus.imem_req), 32'(e.req));
        chk({e.tag, ".valid"},  32'(bus.pc_valid), 32'(e.valid));
        chk({e.tag, ".halted"}, 32'(bus.halted),   32'(e.halted));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic async_reset_test();
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 1);
    #3;
    chk("arst.pre_pc", bus.pc_out, 32'h40);
    #1 rst = 1'b1;
    #1;
    chk("arst.pc",     bus.pc_out, 32'h0);
    chk("arst.req",    32'(bus.imem_req), 32'h0);
    chk("arst.valid",  32'(bus.pc_valid), 32'h0);
    chk("arst.halted", 32'(bus.halted),   32'h0);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("arst.boot_req", 32'(bus.imem_req), 32'h0);
    chk("arst.boot_pc",  bus.pc_out, 32'h0);
    @(posedge clk);
    model_step();
  endtask

  initial begin
    drive(0, 0, 0, 32'h0, 0, 0);
    model_reset();
    repeat (2) cycle(1, 0, 0, 0, 0, 0, 1, "rst");
    repeat (5) cycle(0, 0, 0, 0, 0, 0, 1, "seq");

    cycle(0, 0, 0, 1, 32'h8, 0, 0, "to8");
    repeat (3) cycle(0, 1, 0, 0, 0, 0, 1, "stall");
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, "noack");

    cycle(0, 0, 0, 1, 32'h1003, 0, 1, "br");
    cycle(0, 0, 0, 1, 32'h2000, 1, 1, "trapbr");
    cycle(0, 0, 0, 0, 0, 0, 1, "trapchk");

    cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, "tomax");
    cycle(0, 0, 0, 0, 0, 0, 1, "wrap");
    cycle(0, 0, 0, 0, 0, 0, 0, "wrapchk");

    cycle(0, 0, 0, 1, 32'h10, 0, 0, "to16");
    cycle(0, 0, 1, 0, 0, 0, 1, "halt");
    repeat (2) cycle(0, 0, 0, 1, 32'h2000, 0, 1, "hbr");
    cycle(0, 0, 0, 0, 0, 1, 0, "htrap");
    cycle(0, 0, 0, 0, 0, 0, 0, "htrapchk");

    cycle(1, 0, 0, 0, 0, 0, 0, "rst2");
    cycle(0, 0, 1, 0, 0, 0, 1, "bhalt");
    cycle(0, 0, 0, 0, 0, 0, 1, "bhaltchk");

    cycle(0, 0, 0, 1, 32'h40, 0, 0, "to40");
    async_reset_test();
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 1, "post");

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 5) == 0,
            $urandom(),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) != 0,
            "rnd");
    end

    repeat (2) @(negedge clk);
    #5;
    if (sbq.size() != 0)
      chk("drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
